// File: rtl/uart_com1_if.sv
// ---------------------------------------------------------------------------
// uart_com1_if
// CPU I/O bus bundle for the COM1 serial port.
//   addr  : CPU address (20 bits, decode uses [15:0])
//   wdata : CPU write data
//   wr    : one-cycle I/O write strobe
//   rd    : one-cycle I/O read strobe
//   sel   : read-data select back to the CPU data mux
//   rdata : register read data
// The CPU side uses the master modport, the UART uses the slave modport.
// ---------------------------------------------------------------------------
interface uart_com1_if;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    logic        rd;
    logic        sel;
    logic [7:0]  rdata;

    modport master (
        output addr, wdata, wr, rd,
        input  sel, rdata
    );

    modport slave (
        input  addr, wdata, wr, rd,
        output sel, rdata
    );
endinterface

// File: rtl/uart_com1.sv
// ---------------------------------------------------------------------------
// uart_com1
// 8250-compatible COM1 serial port: fixed 8N1 framing, 16-entry RX FIFO,
// single TX holding register plus shifter, IRQ4 level output.
// Ports:
//   clk  : 10 MHz system clock
//   rst  : synchronous active-high reset
//   bus  : CPU I/O bus (slave), decodes BASE..BASE+7 on addr[15:0]
//   irq  : registered interrupt request to PIC IRQ4, active high
//   rx   : asynchronous serial input, idle high
//   tx   : registered serial output, idle high
// ---------------------------------------------------------------------------
module uart_com1 #(
    parameter logic [15:0] BASE       = 16'h03F8,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PH_INC     = 1152,
    parameter int          PH_MOD     = 6250,
    parameter logic [15:0] DIV_RST    = 16'd12
) (
    input  logic         clk,
    input  logic         rst,
    uart_com1_if.slave   bus,
    output logic         irq,
    input  logic         rx,
    output logic         tx
);

    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [15:0] PH_INC_W = 16'(PH_INC);
    localparam logic [15:0] PH_MOD_W = 16'(PH_MOD);

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_WAIT  = 3'd1;
    localparam logic [2:0] TX_START = 3'd2;
    localparam logic [2:0] TX_DATA  = 3'd3;
    localparam logic [2:0] TX_STOP  = 3'd4;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // A zero divisor means the full 16-bit range plus one (65536).
    function automatic logic [16:0] div_value(input logic [7:0] hi, input logic [7:0] lo);
        if ({hi, lo} == 16'h0000) begin
            div_value = 17'h10000;
        end else begin
            div_value = {1'b0, hi, lo};
        end
    endfunction

    // Interrupt identification in fixed priority order.
    function automatic logic [7:0] iir_calc(input logic [3:0] ier, input logic oe, input logic fe,
                                            input logic dr, input logic thri);
        if (ier[2] && (oe || fe)) begin
            iir_calc = 8'h06;
        end else if (ier[0] && dr) begin
            iir_calc = 8'h04;
        end else if (ier[1] && thri) begin
            iir_calc = 8'h02;
        end else begin
            iir_calc = 8'h01;
        end
    endfunction

    // ---------------- registers ----------------
    logic [15:0] ph_acc_r;
    logic [16:0] div_cnt_r;
    logic        tick16_r;
    logic [7:0]  dll_r, dlm_r, lcr_r;
    logic [3:0]  ier_r;
    logic [4:0]  mcr_r;
    logic [2:0]  tx_state_r;
    logic [7:0]  thr_r, tx_shift_r;
    logic        thre_r, thri_r, tx_r;
    logic [3:0]  tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    logic [1:0]  rx_state_r;
    logic [3:0]  rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_push_r, rx_stop_bad_r;
    logic [7:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic        oe_r, fe_r, irq_r;

    // ---------------- combinational ----------------
    logic [15:0] ph_sum_s;
    logic        ref_tick_s;
    logic        hit_s, rd_hit_s, wr_hit_s, dlab_s;
    logic [2:0]  off_s;
    logic        wr_thr_s, wr_dll_s, wr_dlm_s, wr_ier_s, wr_lcr_s, wr_mcr_s;
    logic        rd_rbr_s, rd_iir_s, rd_lsr_s;
    logic        tx_load_s, thre_set_s, ier_thri_s, iir_clr_s;
    logic        dr_s, temt_s, fifo_full_s, pop_s, push_ok_s;
    logic [7:0]  rbr_s, lsr_s, iir_s, rdata_s;
    logic        addr_unused_s;

    assign addr_unused_s = ^{bus.addr[19:16]};

    // Address decode and strobe qualification.
    always_comb begin
        hit_s    = (bus.addr[15:3] == BASE[15:3]);
        off_s    = bus.addr[2:0];
        dlab_s   = lcr_r[7];
        rd_hit_s = bus.rd & hit_s;
        wr_hit_s = bus.wr & hit_s;
        wr_thr_s = wr_hit_s & (off_s == 3'd0) & ~dlab_s;
        wr_dll_s = wr_hit_s & (off_s == 3'd0) & dlab_s;
        wr_ier_s = wr_hit_s & (off_s == 3'd1) & ~dlab_s;
        wr_dlm_s = wr_hit_s & (off_s == 3'd1) & dlab_s;
        wr_lcr_s = wr_hit_s & (off_s == 3'd3);
        wr_mcr_s = wr_hit_s & (off_s == 3'd4);
        rd_rbr_s = rd_hit_s & (off_s == 3'd0) & ~dlab_s;
        rd_iir_s = rd_hit_s & (off_s == 3'd2);
        rd_lsr_s = rd_hit_s & (off_s == 3'd5);
    end

    // Status, interrupt and FIFO handshake terms.
    always_comb begin
        dr_s        = (count_r != {CNT_W{1'b0}});
        temt_s      = thre_r & (tx_state_r == TX_IDLE);
        fifo_full_s = (count_r == CNT_W'(FIFO_DEPTH));
        pop_s       = rd_rbr_s & dr_s;
        push_ok_s   = rx_push_r & (~fifo_full_s | pop_s);
        // Shifter loads whenever it is idle and the holding register is full;
        // a THR write landing in the same cycle keeps THRE low for the new byte.
        tx_load_s   = (tx_state_r == TX_IDLE) & ~thre_r;
        thre_set_s  = tx_load_s & ~wr_thr_s;
        ier_thri_s  = wr_ier_s & bus.wdata[1] & ~ier_r[1] & thre_r;
        rbr_s       = dr_s ? mem_r[rd_ptr_r] : 8'h00;
        lsr_s       = {1'b0, temt_s, thre_r, 1'b0, fe_r, 1'b0, oe_r, dr_s};
        iir_s       = iir_calc(ier_r, oe_r, fe_r, dr_s, thri_r);
        iir_clr_s   = rd_iir_s & (iir_s == 8'h02);
    end

    // Register read mux, purely a function of the address.
    always_comb begin
        rdata_s = 8'h00;
        case (off_s)
            3'd0:    rdata_s = dlab_s ? dll_r : rbr_s;
            3'd1:    rdata_s = dlab_s ? dlm_r : {4'h0, ier_r};
            3'd2:    rdata_s = iir_s;
            3'd3:    rdata_s = lcr_r;
            3'd4:    rdata_s = {3'b000, mcr_r};
            3'd5:    rdata_s = lsr_s;
            3'd6:    rdata_s = 8'hB0;
            3'd7:    rdata_s = 8'h00;
            default: rdata_s = 8'h00;
        endcase
    end

    assign bus.sel   = rd_hit_s;
    assign bus.rdata = rdata_s;
    assign irq       = irq_r;
    assign tx        = tx_r;

    // Phase accumulator producing the 1.8432 MHz reference tick.
    always_comb begin
        ph_sum_s   = ph_acc_r + PH_INC_W;
        ref_tick_s = (ph_sum_s >= PH_MOD_W);
    end

    // Phase accumulator state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_acc_r <= 16'h0000;
        end else if (ref_tick_s) begin
            ph_acc_r <= ph_sum_s - PH_MOD_W;
        end else begin
            ph_acc_r <= ph_sum_s;
        end
    end

    // Baud divisor counter; a divisor write restarts it with the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= div_value(DIV_RST[15:8], DIV_RST[7:0]);
            tick16_r  <= 1'b0;
        end else if (wr_dll_s) begin
            div_cnt_r <= div_value(dlm_r, bus.wdata);
            tick16_r  <= 1'b0;
        end else if (wr_dlm_s) begin
            div_cnt_r <= div_value(bus.wdata, dll_r);
            tick16_r  <= 1'b0;
        end else if (ref_tick_s) begin
            if (div_cnt_r == 17'd1) begin
                div_cnt_r <= div_value(dlm_r, dll_r);
                tick16_r  <= 1'b1;
            end else begin
                div_cnt_r <= div_cnt_r - 17'd1;
                tick16_r  <= 1'b0;
            end
        end else begin
            tick16_r <= 1'b0;
        end
    end

    // CPU-writable control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dll_r <= DIV_RST[7:0];
            dlm_r <= DIV_RST[15:8];
            ier_r <= 4'h0;
            lcr_r <= 8'h00;
            mcr_r <= 5'h00;
        end else begin
            if (wr_dll_s) dll_r <= bus.wdata;
            if (wr_dlm_s) dlm_r <= bus.wdata;
            if (wr_ier_s) ier_r <= bus.wdata[3:0];
            if (wr_lcr_s) lcr_r <= bus.wdata;
            if (wr_mcr_s) mcr_r <= bus.wdata[4:0];
        end
    end

    // Transmit holding register and THRE flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_r  <= 8'h00;
            thre_r <= 1'b1;
        end else if (wr_thr_s) begin
            thr_r  <= bus.wdata;
            thre_r <= 1'b0;
        end else if (tx_load_s) begin
            thre_r <= 1'b1;
        end
    end

    // Transmit FSM: load, align to tick16, then start/8 data/stop bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_shift_r <= 8'h00;
            tx_cnt_r   <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_r       <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_r <= 1'b1;
                    if (tx_load_s) begin
                        tx_shift_r <= thr_r;
                        tx_state_r <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (tick16_r) begin
                        tx_r       <= 1'b0;
                        tx_cnt_r   <= 4'd0;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick16_r) begin
                        if (tx_cnt_r == 4'd15) begin
                            tx_cnt_r   <= 4'd0;
                            tx_bit_r   <= 3'd0;
                            tx_r       <= tx_shift_r[0];
                            tx_state_r <= TX_DATA;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick16_r) begin
                        if (tx_cnt_r == 4'd15) begin
                            tx_cnt_r <= 4'd0;
                            if (tx_bit_r == 3'd7) begin
                                tx_r       <= 1'b1;
                                tx_state_r <= TX_STOP;
                            end else begin
                                tx_r       <= tx_shift_r[1];
                                tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                                tx_bit_r   <= tx_bit_r + 3'd1;
                            end
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick16_r) begin
                        if (tx_cnt_r == 4'd15) begin
                            tx_cnt_r   <= 4'd0;
                            tx_state_r <= TX_IDLE;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus edge history for the serial input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM: mid-start validation, then samples every 16 tick16s.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r    <= RX_IDLE;
            rx_cnt_r      <= 4'd0;
            rx_bit_r      <= 3'd0;
            rx_shift_r    <= 8'h00;
            rx_push_r     <= 1'b0;
            rx_stop_bad_r <= 1'b0;
        end else begin
            rx_push_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_cnt_r   <= 4'd0;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick16_r) begin
                        if (rx_cnt_r == 4'd7) begin
                            rx_cnt_r <= 4'd0;
                            rx_bit_r <= 3'd0;
                            // A line that is high again at mid-start was a glitch.
                            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick16_r) begin
                        if (rx_cnt_r == 4'd15) begin
                            rx_cnt_r   <= 4'd0;
                            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                            if (rx_bit_r == 3'd7) begin
                                rx_state_r <= RX_STOP;
                            end else begin
                                rx_bit_r <= rx_bit_r + 3'd1;
                            end
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick16_r) begin
                        if (rx_cnt_r == 4'd15) begin
                            rx_cnt_r      <= 4'd0;
                            rx_push_r     <= 1'b1;
                            rx_stop_bad_r <= ~rx_sync_r;
                            rx_state_r    <= RX_IDLE;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // RX FIFO storage; emptiness is tracked by the pointers, not the data.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= rx_shift_r;
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            if (pop_s)     rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Line error flags: a new error wins over a same-cycle LSR read.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_r <= 1'b0;
            fe_r <= 1'b0;
        end else begin
            if (rx_push_r && !push_ok_s) begin
                oe_r <= 1'b1;
            end else if (rd_lsr_s) begin
                oe_r <= 1'b0;
            end
            if (rx_push_r && rx_stop_bad_r) begin
                fe_r <= 1'b1;
            end else if (rd_lsr_s) begin
                fe_r <= 1'b0;
            end
        end
    end

    // THR-empty interrupt latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            thri_r <= 1'b0;
        end else if (thre_set_s || ier_thri_s) begin
            thri_r <= 1'b1;
        end else if (wr_thr_s || iir_clr_s) begin
            thri_r <= 1'b0;
        end
    end

    // Registered interrupt output gated by OUT2.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= mcr_r[3] & ~iir_s[0];
        end
    end

endmodule

// File: tb/tb_uart_com1.sv
module tb_uart_com1;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic tx;
    logic irq;

    uart_com1_if bus ();

    uart_com1 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq),
        .rx  (rx),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q  [$];
    string      name_q [$];
    logic [7:0] mon_exp;
    string      mon_name;

    // Read monitor: every selected read cycle is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.sel === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_read actual=%02h expected=none", bus.rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (bus.rdata !== mon_exp) begin
                    failures = failures + 1;
                    $display("FAIL %s actual=%02h expected=%02h", mon_name, bus.rdata, mon_exp);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
        @(posedge clk); #1;
        bus.addr  = 20'h003F8 + 20'(off);
        bus.wdata = d;
        bus.wr    = 1'b1;
        @(posedge clk); #1;
        bus.wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] off, input logic [7:0] exp, input string name);
        @(posedge clk); #1;
        bus.addr = 20'h003F8 + 20'(off);
        bus.rd   = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk); #1;
        bus.rd   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int bit_cyc);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (bit_cyc) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bit_cyc) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (bit_cyc) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic set_divisor(input logic [7:0] lo, input logic [7:0] hi);
        bus_write(3'd3, 8'h80);
        bus_write(3'd0, lo);
        bus_write(3'd1, hi);
        bus_write(3'd3, 8'h00);
    endtask

    logic [7:0] tx_byte;
    logic       lvl;
    int         cnt;
    int         w;

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        rx        = 1'b1;
        bus.addr  = 20'h00000;
        bus.wdata = 8'h00;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        // Reset defaults
        @(negedge clk);
        check_bit("rst_tx", tx, 1'b1);
        check_bit("rst_irq", irq, 1'b0);
        check_bit("rst_sel", bus.sel, 1'b0);
        bus_read(3'd5, 8'h60, "rst_lsr");
        bus_read(3'd2, 8'h01, "rst_iir");
        bus_read(3'd3, 8'h00, "rst_lcr");
        bus_read(3'd1, 8'h00, "rst_ier");
        bus_read(3'd4, 8'h00, "rst_mcr");
        bus_read(3'd6, 8'hB0, "msr");
        bus_read(3'd7, 8'h00, "scr");
        bus_read(3'd0, 8'h00, "rbr_empty");
        @(posedge clk); #1;
        bus.addr = 20'h002F8;
        bus.rd   = 1'b1;
        @(negedge clk);
        check_bit("sel_out_of_range", bus.sel, 1'b0);
        @(posedge clk); #1;
        bus.rd = 1'b0;

        // RX at 9600 baud with data-ready interrupt
        bus_write(3'd1, 8'h01);
        bus_write(3'd4, 8'h08);
        repeat (3) @(posedge clk);
        #1 check_bit("irq_idle", irq, 1'b0);
        send_byte(8'hA5, 1'b1, 1042);
        check_bit("irq_rx", irq, 1'b1);
        bus_read(3'd2, 8'h04, "iir_rx");
        bus_read(3'd0, 8'hA5, "rbr_a5");
        check_bit("irq_hold_after_pop", irq, 1'b1);
        @(posedge clk); #1;
        check_bit("irq_fall_after_pop", irq, 1'b0);
        bus_read(3'd5, 8'h60, "lsr_after_pop");

        // TX timing at 115200 baud
        bus_write(3'd3, 8'h80);
        bus_read(3'd0, 8'h0C, "dll_reset");
        bus_read(3'd3, 8'h80, "lcr_dlab");
        bus_write(3'd0, 8'h01);
        bus_write(3'd1, 8'h00);
        bus_read(3'd0, 8'h01, "dll_new");
        bus_write(3'd3, 8'h00);
        tx_byte = 8'h55;
        bus_write(3'd0, tx_byte);
        fork
            begin
                w = 0;
                while (tx !== 1'b0 && w < 100) begin
                    @(negedge clk);
                    w = w + 1;
                end
                check_bit("tx_start_seen", tx, 1'b0);
                for (int k = 0; k < 9; k++) begin
                    lvl = tx;
                    cnt = 0;
                    do begin
                        @(negedge clk);
                        cnt = cnt + 1;
                    end while (tx === lvl && cnt < 200);
                    check_bit("tx_level", lvl, (k == 0) ? 1'b0 : tx_byte[k-1]);
                    checks = checks + 1;
                    if (cnt < 86 || cnt > 87) begin
                        failures = failures + 1;
                        $display("FAIL tx_bit_len bit=%0d actual=%0d expected=86..87", k, cnt);
                    end
                end
                check_bit("tx_stop", tx, 1'b1);
            end
            begin
                repeat (300) @(posedge clk);
                bus_read(3'd5, 8'h20, "lsr_mid_frame");
            end
        join
        repeat (120) @(posedge clk);
        bus_read(3'd5, 8'h60, "lsr_after_stop");

        // FIFO overrun: 17 bytes without reading
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1, 87);
        end
        repeat (20) @(posedge clk);
        bus_read(3'd5, 8'h63, "lsr_overrun");
        for (int i = 0; i < 16; i++) begin
            bus_read(3'd0, 8'(i), "rbr_fifo");
        end
        bus_read(3'd5, 8'h60, "lsr_drained");

        // Framing error
        bus_write(3'd1, 8'h04);
        send_byte(8'h3C, 1'b0, 87);
        repeat (20) @(posedge clk);
        bus_read(3'd2, 8'h06, "iir_fe");
        bus_read(3'd5, 8'h69, "lsr_fe");
        bus_read(3'd2, 8'h01, "iir_fe_cleared");
        bus_read(3'd0, 8'h3C, "rbr_fe_byte");

        // THRE interrupt
        bus_write(3'd1, 8'h02);
        repeat (3) @(posedge clk);
        #1 check_bit("irq_thre", irq, 1'b1);
        bus_read(3'd2, 8'h02, "iir_thre");
        bus_read(3'd2, 8'h01, "iir_thre_cleared");
        repeat (3) @(posedge clk);
        #1 check_bit("irq_thre_cleared", irq, 1'b0);
        bus_write(3'd0, 8'h81);
        repeat (1100) @(posedge clk);
        bus_read(3'd2, 8'h02, "iir_thre_again");
        bus_read(3'd5, 8'h60, "lsr_tx_done");
        #1 check_bit("tx_idle_after", tx, 1'b1);

        // Glitch rejection at 9600 baud
        set_divisor(8'h0C, 8'h00);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (200) @(posedge clk);
        #1 rx = 1'b1;
        repeat (11000) @(posedge clk);
        bus_read(3'd5, 8'h60, "lsr_glitch");
        bus_read(3'd2, 8'h01, "iir_glitch");

        // Reset in the middle of a frame
        bus_write(3'd0, 8'h00);
        repeat (300) @(posedge clk);
        #1 check_bit("tx_mid_frame", tx, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_bit("tx_after_rst", tx, 1'b1);
        repeat (200) @(posedge clk);
        #1 check_bit("tx_stays_idle", tx, 1'b1);
        bus_read(3'd5, 8'h60, "lsr_after_rst");

        repeat (5) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_com1.md
Name: uart_com1

Overview:
- 8250-compatible serial port (COM1) on the internal CPU bus. Provides a serial-mouse/debug link.
- Decodes I/O 0x3F8-0x3FF and returns read data through the top-level read-data mux (oSel/oData).
- Drives IRQ4 into the PIC.
- Fixed 8N1 framing, 16-entry RX FIFO, single TX holding register plus shift register.

Parameters:
- BASE, 16'h03F8, I/O base; decodes BASE..BASE+7 against iAddr[15:0].
- FIFO_DEPTH, 16, RX FIFO entries (power of two).
- PH_INC, 1152, phase-accumulator increment per iClk.
- PH_MOD, 6250, phase-accumulator modulus. PH_INC/PH_MOD = 1.8432 MHz / 10 MHz.
- DIV_RST, 16'd12, divisor latch reset value (9600 baud).

Ports:
- iClk  in  1  system clock, 10 MHz.
- iRst  in  1  reset; synchronous, active-high.
- iAddr  in  20  CPU address.
- iData  in  8  CPU write data.
- iWr  in  1  I/O write strobe, one cycle per access.
- iRd  in  1  I/O read strobe, one cycle per access.
- oSel  out  1  read-data select for the CPU data mux.
- oData  out  8  register read data.
- oIrq  out  1  interrupt request to PIC IRQ4, active-high level.
- iRx  in  1  serial input, asynchronous, idle high.
- oTx  out  1  serial output, idle high.

Behaviour:
- Clock and reset:
  - Single clock domain (iClk).
  - iRx passes through a 2-flop synchroniser before use.
  - Reset values: oTx=1, oIrq=0, oSel=0, IER=0, LCR=0, MCR=0, DLL/DLM=DIV_RST, FIFO empty, OE=FE=0, THRE=TEMT=1, both FSMs in IDLE, accumulators cleared.
  - Reset mid-frame aborts the frame: oTx returns to 1 on the next cycle.
- Baud generation:
  - Phase accumulator: adds PH_INC each cycle; when the sum reaches PH_MOD it subtracts PH_MOD and emits a ref tick.
  - Divisor counter: decrements on each ref tick; at 1 it reloads {DLM,DLL} and emits tick16 (16x baud).
  - Divisor 0 is treated as 65536.
  - Writing DLL or DLM reloads the counter immediately.
- Bus interface:
  - oSel = iRd & address in range, combinational. oData is combinational from iAddr.
  - Read side effects (FIFO pop, flag clears) occur in the iRd cycle. Write effects are visible the next cycle.
- Register map (offset: read / write):
  - 0, DLAB=0: RBR (FIFO head, pop; reads 0 when empty) / THR.
  - 0, DLAB=1: DLL / DLL.
  - 1, DLAB=0: IER[3:0], upper bits read 0 / IER.
  - 1, DLAB=1: DLM / DLM.
  - 2: IIR / ignored.
  - 3: LCR / LCR. Only bit7 (DLAB) affects behaviour; all 8 bits read back.
  - 4: MCR[4:0] / MCR. Bit3 = OUT2 gates oIrq.
  - 5: LSR = {0, TEMT, THRE, 0, FE, 0, OE, DR}. Reading LSR clears OE and FE.
  - 6, 7: read 0xB0 (MSR with CTS/DSR/DCD asserted) and 0x00 / ignored.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE. Each bit lasts 16 tick16s.
  - A THR write sets THRE=0.
  - In IDLE with THR full, the FSM loads the shifter on the next cycle and sets THRE=1. It starts at the following tick16.
  - TEMT = THRE & shifter IDLE.
  - A THR write while THRE=0 overwrites the held byte.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - On a falling edge, count 8 tick16s, then resample: low continues; high returns to IDLE (glitch).
  - Data bits sampled every 16 tick16s thereafter, LSB first.
  - Stop sample low sets FE=1; the byte is still pushed.
  - Push when the FIFO is full: byte dropped, OE=1.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - DR = FIFO not empty.
- IIR and interrupts:
  - IIR priority: 0x06 if IER[2] & (OE|FE); else 0x04 if IER[0] & DR; else 0x02 if IER[1] & thri; else 0x01.
  - thri is set when THRE rises or IER[1] goes 0->1 with THRE=1.
  - thri is cleared by a THR write, or by an IIR read that returns 0x02.
  - oIrq is registered: oIrq = MCR[3] & (IIR[0]==0), one cycle latency.

Test Plan:
- Reset defaults: after iRst, read offset 5 -> 0x60, offset 2 -> 0x01, offset 3 -> 0x00. oTx=1, oIrq=0, oSel=1 only during reads of 0x3F8-0x3FF.
- TX timing: DLAB=1, DLL=1, DLM=0 (115200 baud), then write 0x55 to THR.
  - oTx shows start bit, 1,0,1,0,1,0,1,0, then stop bit.
  - Each bit lasts 86-87 cycles.
  - LSR reads 0x20 mid-frame and 0x60 after the stop bit.
- RX with interrupt: drive 0xA5 8N1 at 9600 baud (1042 cycles/bit) with IER=0x01, MCR=0x08.
  - oIrq rises after the stop sample; IIR=0x04; RBR=0xA5.
  - oIrq falls one cycle after the pop; LSR bit0 then reads 0.
- FIFO overrun: send 17 bytes 0x00..0x10 without reading.
  - LSR=0x63 (OE set).
  - 16 reads return 0x00..0x0F; LSR then shows OE cleared and DR=0.
- Framing error and glitch:
  - Byte with stop bit low -> FE=1 and the byte is still in the FIFO; IIR=0x06 when IER[2]=1.
  - A 200-cycle low pulse on iRx -> no byte received.
- THRE interrupt: IER=0x02 with THRE=1 -> IIR=0x02; a second IIR read -> 0x01; a THR write followed by transmit-complete re-raises 0x02.
